lcd_bus_sequencer: RTL and testbench



---
 rtl/lcd_pkg.sv | 52 +++++
 rtl/lcd_phase_timer.sv | 46 ++++
 rtl/lcd_bus_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_lcd_bus_sequencer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared types and constants for the HD44780 character-LCD bus sequencer.
//   lcd_state_e  : sequencer FSM states
//   lcd_byte_t   : one latched bus transfer (register select + data byte)
//   init ROM     : fixed power-up command sequence, fetched with init_byte()
//   is_slow_cmd  : detects clear/home commands that need the long exec wait
// -----------------------------------------------------------------------------
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    typedef struct packed {
        logic       rs;     // 0 = command, 1 = data
        logic [7:0] data;
    } lcd_byte_t;

    // Init ROM: 8-bit bus, 2 lines, 5x8 font; display on / cursor off;
    // clear; increment without shift.
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;

    localparam int INIT_LEN   = 4;
    localparam int INIT_IDX_W = 2;

    function automatic logic [7:0] init_byte(input logic [INIT_IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = LCD_FUNC_SET;
            2'd1:    b = LCD_DISP_ON;
            2'd2:    b = LCD_CLEAR;
            default: b = LCD_ENTRY;
        endcase
        return b;
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) take ~1.6 ms on the
    // controller; every other command and all data writes take ~40 us.
    function automatic logic is_slow_cmd(input lcd_byte_t b);
        return (b.rs == 1'b0) && (b.data[7:2] == 6'd0) && (b.data[1:0] != 2'd0);
    endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// -----------------------------------------------------------------------------
// lcd_phase_timer
// Loadable down-counter shared by every sequencer phase. A phase of N cycles
// is started by loading N-1; done_o is high while the count sits at zero,
// i.e. during the last cycle of the phase. The count parks at zero.
//
// Ports:
//   clk_i         clock
//   rst_ni        asynchronous active-low reset (count <- RST_VAL)
//   load_i        load load_value_i this cycle (has priority over counting)
//   load_value_i  phase length minus one
//   done_o        count is zero
// -----------------------------------------------------------------------------
module lcd_phase_timer #(
    parameter int           W       = 20,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_bus_sequencer
// Owns the DE2 HD44780 character-LCD pins. After reset it waits T_PWRUP
// cycles, writes the four-byte init sequence, then accepts one command/data
// byte at a time over valid/ready. Each byte is driven through the phases
// SETUP (T_AS) -> PULSE (EN high, T_PW) -> HOLD (T_H) -> WAIT (T_EXEC or
// T_CLR for clear/home) before the next byte may start.
//
// Ports:
//   CLOCK_50   sole clock
//   RST_N      asynchronous active-low reset
//   req_valid  requester has a byte
//   req_ready  sequencer accepts a byte this cycle (registered)
//   req_rs     0 = command, 1 = data
//   req_data   byte to transfer
//   LCD_RS     register select
//   LCD_RW     always 0, the bus is write-only
//   LCD_EN     enable strobe (straight from a flop, glitch-free)
//   LCD_DATA   data bus
//   init_done  init sequence complete, sticky until reset
//   busy       high in every state except IDLE
//
// All phase lengths must be >= 1 cycle; the timer is loaded with length-1.
// -----------------------------------------------------------------------------
module lcd_bus_sequencer
    import lcd_pkg::*;
#(
    parameter int T_AS    = 2,
    parameter int T_PW    = 25,
    parameter int T_H     = 2,
    parameter int T_EXEC  = 2000,
    parameter int T_CLR   = 82000,
    parameter int T_PWRUP = 750000
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA,
    output logic       init_done,
    output logic       busy
);

    // Timer width covers the longest phase.
    localparam int M0 = (T_AS   > T_PW)    ? T_AS   : T_PW;
    localparam int M1 = (T_H    > T_EXEC)  ? T_H    : T_EXEC;
    localparam int M2 = (T_CLR  > T_PWRUP) ? T_CLR  : T_PWRUP;
    localparam int M3 = (M0     > M1)      ? M0     : M1;
    localparam int TMAX = (M3   > M2)      ? M3     : M2;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] LD_AS    = TW'(T_AS - 1);
    localparam logic [TW-1:0] LD_PW    = TW'(T_PW - 1);
    localparam logic [TW-1:0] LD_H     = TW'(T_H - 1);
    localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC - 1);
    localparam logic [TW-1:0] LD_CLR   = TW'(T_CLR - 1);
    localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP - 1);

    localparam logic [INIT_IDX_W-1:0] INIT_LAST = INIT_IDX_W'(INIT_LEN - 1);

    lcd_state_e              state_q, state_d;
    lcd_byte_t               byte_q, byte_d;
    logic [INIT_IDX_W-1:0]   idx_q, idx_d;
    logic                    done_q, done_d;
    logic                    en_q, en_d;
    logic                    ready_q, ready_d;
    logic                    busy_q, busy_d;

    logic                    tmr_load;
    logic [TW-1:0]           tmr_value;
    logic                    tmr_done;

    // Reset value puts the timer straight into the power-up wait, so the
    // PWRUP phase needs no explicit load.
    lcd_phase_timer #(
        .W       (TW),
        .RST_VAL (LD_PWRUP)
    ) u_timer (
        .clk_i        (CLOCK_50),
        .rst_ni       (RST_N),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .done_o       (tmr_done)
    );

    // -------------------------------------------------------------------------
    // Next state, timer control and next values of the registered outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        idx_d     = idx_q;
        done_d    = done_q;
        tmr_load  = 1'b0;
        tmr_value = '0;

        case (state_q)
            ST_PWRUP: begin
                if (tmr_done) begin
                    state_d     = ST_SETUP;
                    idx_d       = '0;
                    byte_d.rs   = 1'b0;
                    byte_d.data = init_byte('0);
                    tmr_load    = 1'b1;
                    tmr_value   = LD_AS;
                end
            end

            ST_SETUP: begin
                if (tmr_done) begin
                    state_d   = ST_PULSE;
                    tmr_load  = 1'b1;
                    tmr_value = LD_PW;
                end
            end

            ST_PULSE: begin
                if (tmr_done) begin
                    state_d   = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_value = LD_H;
                end
            end

            ST_HOLD: begin
                if (tmr_done) begin
                    state_d   = ST_WAIT;
                    tmr_load  = 1'b1;
                    tmr_value = is_slow_cmd(byte_q) ? LD_CLR : LD_EXEC;
                end
            end

            ST_WAIT: begin
                if (tmr_done) begin
                    if (!done_q && (idx_q != INIT_LAST)) begin
                        // Still inside the init sequence: fetch the next ROM byte.
                        state_d     = ST_SETUP;
                        idx_d       = idx_q + 1'b1;
                        byte_d.rs   = 1'b0;
                        byte_d.data = init_byte(idx_q + 1'b1);
                        tmr_load    = 1'b1;
                        tmr_value   = LD_AS;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end

            ST_IDLE: begin
                // ready_q is a flop, so accept never depends combinationally
                // on req_valid reaching req_ready.
                if (req_valid && ready_q) begin
                    state_d     = ST_SETUP;
                    byte_d.rs   = req_rs;
                    byte_d.data = req_data;
                    tmr_load    = 1'b1;
                    tmr_value   = LD_AS;
                end
            end

            default: begin
                state_d = ST_PWRUP;
            end
        endcase

        // Registered outputs are computed from the next state so they line
        // up with the state they describe.
        en_d    = (state_d == ST_PULSE);
        ready_d = (state_d == ST_IDLE) && done_d;
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_PWRUP;
            byte_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            en_q    <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            en_q    <= en_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign LCD_RS    = byte_q.rs;
    assign LCD_DATA  = byte_q.data;
    assign LCD_RW    = 1'b0;
    assign LCD_EN    = en_q;
    assign req_ready = ready_q;
    assign init_done = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Scoreboard bench for lcd_bus_sequencer. Stimulus pushes the byte it expects
// on the LCD bus (plus the expected idle gap after the strobe); a monitor pops
// one entry per EN pulse and checks data, pulse width, hold stability and gap.
module tb_lcd_bus_sequencer;

    localparam int T_AS    = 1;
    localparam int T_PW    = 3;
    localparam int T_H     = 1;
    localparam int T_EXEC  = 5;
    localparam int T_CLR   = 20;
    localparam int T_PWRUP = 10;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         gap;   // EN-low, busy-high samples after the pulse
    } exp_t;

    logic       CLOCK_50;
    logic       RST_N;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       LCD_EN;
    logic [7:0] LCD_DATA;
    logic       init_done;
    logic       busy;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    lcd_bus_sequencer #(
        .T_AS(T_AS), .T_PW(T_PW), .T_H(T_H),
        .T_EXEC(T_EXEC), .T_CLR(T_CLR), .T_PWRUP(T_PWRUP)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .RST_N     (RST_N),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_EN    (LCD_EN),
        .LCD_DATA  (LCD_DATA),
        .init_done (init_done),
        .busy      (busy)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, want);
    endtask

    task automatic push(input logic rs, input logic [7:0] d, input int gap);
        exp_t e;
        e.rs = rs; e.data = d; e.gap = gap;
        sb.push_back(e);
    endtask

    // Init: 38/0C wait T_EXEC then next SETUP; 01 waits T_CLR; 06 ends in IDLE.
    task automatic push_init();
        push(1'b0, 8'h38, T_H + T_EXEC + T_AS);
        push(1'b0, 8'h0C, T_H + T_EXEC + T_AS);
        push(1'b0, 8'h01, T_H + T_CLR + T_AS);
        push(1'b0, 8'h06, T_H + T_EXEC);
    endtask

    function automatic int user_gap(input logic rs, input logic [7:0] d);
        if (rs == 1'b0 && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return T_H + T_CLR;
        return T_H + T_EXEC;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge CLOCK_50);
        while (!req_ready && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!req_ready) check("ready_timeout", 0, 1);
    endtask

    // Returns just after the accepting edge.
    task automatic send(input logic rs, input logic [7:0] d);
        wait_ready();
        push(rs, d, user_gap(rs, d));
        req_rs = rs; req_data = d; req_valid = 1'b1;
        @(posedge CLOCK_50);
        #1 req_valid = 1'b0;
    endtask

    // ------------------------------------------------------------------ monitor
    initial begin : monitor
        int   phase;
        int   pw;
        int   gap;
        bit   hold_ok;
        exp_t cur;
        phase = 0; pw = 0; gap = 0; hold_ok = 1'b1;
        cur.rs = 1'b0; cur.data = 8'h00; cur.gap = 0;
        forever begin
            @(negedge CLOCK_50);
            if (!RST_N) begin
                phase = 0;
            end else begin
                if (phase == 2) begin
                    if (!LCD_EN && busy) begin
                        if (gap < T_H && (LCD_DATA != cur.data || LCD_RS != cur.rs)) hold_ok = 1'b0;
                        gap++;
                    end else begin
                        check("post_pulse_gap", gap, cur.gap);
                        check("hold_stable", int'(hold_ok), 1);
                        phase = 0;
                    end
                end
                if (phase == 1) begin
                    if (LCD_EN) begin
                        pw++;
                        if (LCD_DATA != cur.data || LCD_RS != cur.rs) hold_ok = 1'b0;
                    end else begin
                        check("pulse_width", pw, T_PW);
                        if (LCD_DATA != cur.data || LCD_RS != cur.rs) hold_ok = 1'b0;
                        gap = 1;
                        phase = 2;
                    end
                end else if (phase == 0 && LCD_EN) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pulse", int'(LCD_DATA), -1);
                        cur.rs = LCD_RS; cur.data = LCD_DATA; cur.gap = 0;
                    end else begin
                        cur = sb.pop_front();
                        check("pulse_rs", int'(LCD_RS), int'(cur.rs));
                        check("pulse_data", int'(LCD_DATA), int'(cur.data));
                    end
                    pw = 1; hold_ok = 1'b1; phase = 1;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ----------------------------------------------------------------- stimulus
    initial begin : stim
        int n;
        int en_first;
        int rdy_at;
        logic [7:0] stream [3];

        RST_N = 1'b0; req_valid = 1'b0; req_rs = 1'b0; req_data = 8'h00;
        repeat (2) @(negedge CLOCK_50);
        check("rst_en", int'(LCD_EN), 0);
        check("rst_rs", int'(LCD_RS), 0);
        check("rst_rw", int'(LCD_RW), 0);
        check("rst_data", int'(LCD_DATA), 0);
        check("rst_ready", int'(req_ready), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_busy", int'(busy), 1);

        // Power-up wait and init sequence.
        push_init();
        RST_N = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge CLOCK_50);
            if (LCD_EN) break;
            n++;
        end
        check("pwrup_en_low_samples", n, T_PWRUP + T_AS - 1);
        check("init_done_during_init", int'(init_done), 0);
        wait_ready();
        check("init_done_after_init", int'(init_done), 1);
        check("busy_in_idle", int'(busy), 0);
        check("init_bytes_consumed", sb.size(), 0);

        // Data byte 'A' with latency checks relative to the accepting edge.
        send(1'b1, 8'h41);
        check("acc_rs", int'(LCD_RS), 1);
        check("acc_data", int'(LCD_DATA), 8'h41);
        check("acc_ready_drop", int'(req_ready), 0);
        en_first = -1; rdy_at = -1;
        for (int j = 1; j <= 30; j++) begin
            @(posedge CLOCK_50);
            #1;
            if (LCD_EN && en_first < 0) en_first = j;
            if (req_ready) begin
                rdy_at = j;
                break;
            end
        end
        check("en_rise_offset", en_first, T_AS);
        check("ready_return_offset", rdy_at, T_AS + T_PW + T_H + T_EXEC);

        // Slow (clear) vs normal (set DDRAM address) command waits.
        send(1'b0, 8'h01);
        send(1'b0, 8'h80);

        // req_* churn while busy must not disturb the latched byte.
        send(1'b1, 8'h5A);
        for (int j = 0; j < 8; j++) begin
            req_data = 8'($urandom);
            req_rs   = ~req_rs;
            @(posedge CLOCK_50);
            #1;
        end
        wait_ready();
        check("idle_data_holds", int'(LCD_DATA), 8'h5A);

        // Reset with req_valid already high: nothing accepted before init ends.
        @(negedge CLOCK_50);
        RST_N = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        sb.delete();
        push_init();
        stream[0] = 8'h48; stream[1] = 8'h49; stream[2] = 8'h21;
        req_rs = 1'b1; req_data = stream[0]; req_valid = 1'b1;
        push(1'b1, stream[0], T_H + T_EXEC);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_ready();
            check("stream_accept_after_init", int'(init_done), 1);
            @(posedge CLOCK_50);
            #1;
            if (i < 2) begin
                req_data = stream[i + 1];
                push(1'b1, stream[i + 1], T_H + T_EXEC);
            end else begin
                req_valid = 1'b0;
            end
        end
        wait_ready();
        check("stream_bytes_consumed", sb.size(), 0);

        // Reset in the middle of an enable pulse.
        send(1'b1, 8'h33);
        @(posedge CLOCK_50);
        #3;
        check("en_before_reset", int'(LCD_EN), 1);
        RST_N = 1'b0;
        #1;
        check("async_rst_en", int'(LCD_EN), 0);
        check("async_rst_init_done", int'(init_done), 0);
        check("async_rst_busy", int'(busy), 1);
        repeat (2) @(negedge CLOCK_50);
        sb.delete();
        push_init();
        RST_N = 1'b1;
        wait_ready();
        check("reinit_done", int'(init_done), 1);
        check("reinit_bytes_consumed", sb.size(), 0);

        send(1'b1, 8'h42);
        wait_ready();
        check("final_queue_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
